// File: rtl/connect_four_pkg.sv
// Shared definitions for the connect-four piece dropper.
//   NUM_ROWS / NUM_COLS : board geometry (row 0 = bottom, column 0 = rightmost bit)
//   state_e             : dropper FSM states
//   player_e            : side to move
//   is_onehot           : true when exactly one column bit is set
//   onehot_to_idx       : column index of a one-hot column vector
package connect_four_pkg;

    localparam int NUM_ROWS = 6;
    localparam int NUM_COLS = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DROP   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    typedef enum logic {
        PLAYER_RED   = 1'b0,
        PLAYER_GREEN = 1'b1
    } player_e;

    function automatic logic is_onehot(input logic [NUM_COLS-1:0] v);
        return (v != '0) && ((v & (v - 7'd1)) == '0);
    endfunction

    function automatic logic [2:0] onehot_to_idx(input logic [NUM_COLS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/drop_timer.sv
// Per-row dwell counter for the falling piece.
//   clk      : clock
//   reset    : asynchronous active-high reset, count -> 0
//   clear    : synchronous clear, count -> 0
//   enable   : advance the count; wraps to 0 after DROP_TICKS-1
//   terminal : high while the count sits on its last value (DROP_TICKS-1)
module drop_timer #(
    parameter int DROP_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int              CNT_W = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DROP_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign terminal = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = terminal ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piece_dropper.sv
// Connect-four piece dropper: accepts a column request, animates the piece
// falling from the top row down to the column's stack height, then commits
// it into the mover's plane and hands the turn to the other player.
//   clk, reset     : clock, asynchronous active-high reset
//   enter          : one-cycle drop request for column_select
//   column_select  : one-hot column (bit 0 = column 0)
//   red_board      : committed red cells plus falling red piece, [row][col]
//   green_board    : same for green
//   player         : side to move (0 red, 1 green)
//   busy           : drop in progress
//   placed         : one-cycle pulse while the piece commits
//   rejected       : one-cycle pulse the cycle after a refused enter
//   column_full    : per-column full flags
//   board_full     : all 42 cells occupied
module piece_dropper
    import connect_four_pkg::*;
#(
    parameter int DROP_TICKS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enter,
    input  logic [NUM_COLS-1:0]                column_select,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  red_board,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  green_board,
    output logic                               player,
    output logic                               busy,
    output logic                               placed,
    output logic                               rejected,
    output logic [NUM_COLS-1:0]                column_full,
    output logic                               board_full
);

    localparam logic [2:0] TOP_ROW = 3'(NUM_ROWS - 1);
    localparam logic [2:0] FULL_H  = 3'(NUM_ROWS);

    state_e                            state_q, state_d;
    player_e                           player_q, player_d;
    logic [2:0]                        col_q, col_d;
    logic [2:0]                        target_q, target_d;
    logic [2:0]                        fall_row_q, fall_row_d;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] red_q, red_d;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] green_q, green_d;
    logic [NUM_COLS-1:0][2:0]          height_q, height_d;
    logic                              placed_q, placed_d;
    logic                              rejected_q, rejected_d;

    logic                              tick_clear, tick_enable, tick_terminal;
    logic [2:0]                        sel_idx;
    logic                              sel_ok;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] falling;

    drop_timer #(
        .DROP_TICKS (DROP_TICKS)
    ) u_drop_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tick_clear),
        .enable   (tick_enable),
        .terminal (tick_terminal)
    );

    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            column_full[c] = (height_q[c] == FULL_H);
        end
    end

    assign board_full = &column_full;

    assign sel_idx = onehot_to_idx(column_select);
    assign sel_ok  = is_onehot(column_select) && ((column_select & column_full) == '0)
                     && !board_full;

    // The in-flight piece is overlaid on the mover's plane only; it is never
    // stored until COMMIT, so a reset simply makes it vanish.
    always_comb begin
        falling = '0;
        if (state_q != ST_IDLE) begin
            falling[fall_row_q][col_q] = 1'b1;
        end
    end

    assign red_board   = red_q   | ((player_q == PLAYER_RED)   ? falling : '0);
    assign green_board = green_q | ((player_q == PLAYER_GREEN) ? falling : '0);
    assign player      = player_q;
    assign busy        = (state_q != ST_IDLE);
    assign placed      = placed_q;
    assign rejected    = rejected_q;

    always_comb begin
        state_d     = state_q;
        player_d    = player_q;
        col_d       = col_q;
        target_d    = target_q;
        fall_row_d  = fall_row_q;
        red_d       = red_q;
        green_d     = green_q;
        height_d    = height_q;
        placed_d    = 1'b0;
        rejected_d  = 1'b0;
        tick_clear  = 1'b1;
        tick_enable = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enter) begin
                    if (sel_ok) begin
                        col_d      = sel_idx;
                        target_d   = height_q[sel_idx];
                        fall_row_d = TOP_ROW;
                        state_d    = ST_DROP;
                    end else begin
                        rejected_d = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                tick_clear  = 1'b0;
                tick_enable = 1'b1;
                rejected_d  = enter;
                if (tick_terminal) begin
                    if (fall_row_q == target_q) begin
                        state_d  = ST_COMMIT;
                        // Raised on entry so the registered pulse lines up
                        // with the single COMMIT cycle.
                        placed_d = 1'b1;
                    end else begin
                        fall_row_d = fall_row_q - 3'd1;
                    end
                end
            end
            ST_COMMIT: begin
                rejected_d = enter;
                if (player_q == PLAYER_RED) begin
                    red_d[fall_row_q][col_q] = 1'b1;
                end else begin
                    green_d[fall_row_q][col_q] = 1'b1;
                end
                height_d[col_q] = height_q[col_q] + 3'd1;
                player_d   = (player_q == PLAYER_RED) ? PLAYER_GREEN : PLAYER_RED;
                fall_row_d = TOP_ROW;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            player_q   <= PLAYER_RED;
            col_q      <= '0;
            target_q   <= '0;
            fall_row_q <= TOP_ROW;
            red_q      <= '0;
            green_q    <= '0;
            height_q   <= '0;
            placed_q   <= 1'b0;
            rejected_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            player_q   <= player_d;
            col_q      <= col_d;
            target_q   <= target_d;
            fall_row_q <= fall_row_d;
            red_q      <= red_d;
            green_q    <= green_d;
            height_q   <= height_d;
            placed_q   <= placed_d;
            rejected_q <= rejected_d;
        end
    end

endmodule

// File: tb/tb_piece_dropper.sv
module tb_piece_dropper;

    typedef logic [5:0][6:0] board_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enter = 1'b0;
    logic [6:0] column_select = '0;
    board_t     red_board, green_board;
    logic       player, busy, placed, rejected, board_full;
    logic [6:0] column_full;

    int tests_run = 0;
    int fails = 0;

    piece_dropper #(.DROP_TICKS(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .enter         (enter),
        .column_select (column_select),
        .red_board     (red_board),
        .green_board   (green_board),
        .player        (player),
        .busy          (busy),
        .placed        (placed),
        .rejected      (rejected),
        .column_full   (column_full),
        .board_full    (board_full)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        reset = 1'b1;
        enter = 1'b0;
        column_select = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Issue one enter and follow the drop until busy falls (bounded).
    task automatic drop_and_wait(input logic [6:0] sel, output int busy_n,
                                 output int placed_n, output bit tmo);
        busy_n = 0;
        placed_n = 0;
        tmo = 1'b0;
        @(negedge clk);
        enter = 1'b1;
        column_select = sel;
        @(negedge clk);
        enter = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            busy_n++;
            if (placed) placed_n++;
            @(negedge clk);
        end
        if (busy) tmo = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (red_board !== '0 || green_board !== '0) begin
            fails++;
            $display("FAIL reset_boards: red=%h green=%h required 0", red_board, green_board);
        end
        tests_run++;
        if ({player, busy, placed, rejected, board_full} !== 5'b0 || column_full !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: p=%b busy=%b pl=%b rj=%b bf=%b cf=%b required all 0",
                     player, busy, placed, rejected, board_full, column_full);
        end
    endtask

    task automatic test_single_drop();
        int     k;
        int     placed_n;
        int     placed_k;
        bit     path_ok;
        int     row;
        board_t exp;
        apply_reset();
        @(negedge clk);
        enter = 1'b1;
        column_select = 7'b0000001;
        @(negedge clk);
        enter = 1'b0;
        k = 0;
        placed_n = 0;
        placed_k = -1;
        path_ok = 1'b1;
        while (busy && k < 200) begin
            row = (k < 12) ? 5 - k / 2 : 0;
            exp = '0;
            exp[row][0] = 1'b1;
            if (red_board !== exp || green_board !== '0) path_ok = 1'b0;
            if (placed) begin
                placed_n++;
                placed_k = k;
            end
            k++;
            @(negedge clk);
        end
        tests_run++;
        if (k !== 13) begin
            fails++;
            $display("FAIL single_busy_cycles: got %0d required 13", k);
        end
        tests_run++;
        if (!path_ok) begin
            fails++;
            $display("FAIL single_fall_path: got mismatching falling-piece position required rows 5..0 two cycles each");
        end
        tests_run++;
        if (placed_n !== 1 || placed_k !== 12) begin
            fails++;
            $display("FAIL single_placed: got %0d pulses at cycle %0d required 1 at cycle 12", placed_n, placed_k);
        end
        tests_run++;
        if (red_board !== board_t'(42'h1) || green_board !== '0) begin
            fails++;
            $display("FAIL single_board: red=%h green=%h required red=1 green=0", red_board, green_board);
        end
        tests_run++;
        if (player !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_player: player=%b busy=%b required 1 0", player, busy);
        end
    endtask

    task automatic test_invalid_select();
        logic [6:0] sels [2];
        sels[0] = 7'b0000101;
        sels[1] = 7'b0000000;
        apply_reset();
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            enter = 1'b1;
            column_select = sels[s];
            @(negedge clk);
            enter = 1'b0;
            tests_run++;
            if (rejected !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL invalid_reject_%0d: rejected=%b busy=%b required 1 0", s, rejected, busy);
            end
            @(negedge clk);
            tests_run++;
            if (rejected !== 1'b0 || busy !== 1'b0 || red_board !== '0 || player !== 1'b0) begin
                fails++;
                $display("FAIL invalid_after_%0d: rejected=%b busy=%b red=%h player=%b required 0 0 0 0",
                         s, rejected, busy, red_board, player);
            end
        end
    endtask

    task automatic test_column_full();
        int     bn, pn;
        bit     tmo;
        int     last_bn;
        bit     drops_ok;
        board_t exp_r, exp_g;
        apply_reset();
        drops_ok = 1'b1;
        last_bn = 0;
        exp_r = '0;
        exp_g = '0;
        for (int n = 0; n < 6; n++) begin
            drop_and_wait(7'b0001000, bn, pn, tmo);
            if (tmo || pn != 1) drops_ok = 1'b0;
            last_bn = bn;
            if (n % 2 == 0) exp_r[n][3] = 1'b1;
            else            exp_g[n][3] = 1'b1;
        end
        tests_run++;
        if (!drops_ok || last_bn !== 3) begin
            fails++;
            $display("FAIL col3_drops: ok=%b top-row busy=%0d required ok=1 busy=3", drops_ok, last_bn);
        end
        tests_run++;
        if (column_full !== 7'b0001000 || board_full !== 1'b0) begin
            fails++;
            $display("FAIL col3_full: column_full=%b board_full=%b required 0001000 0", column_full, board_full);
        end
        tests_run++;
        if (red_board !== exp_r || green_board !== exp_g || player !== 1'b0) begin
            fails++;
            $display("FAIL col3_board: red=%h green=%h player=%b required %h %h 0",
                     red_board, green_board, player, exp_r, exp_g);
        end
        @(negedge clk);
        enter = 1'b1;
        column_select = 7'b0001000;
        @(negedge clk);
        enter = 1'b0;
        tests_run++;
        if (rejected !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL col3_seventh: rejected=%b busy=%b required 1 0", rejected, busy);
        end
        @(negedge clk);
        tests_run++;
        if (rejected !== 1'b0 || red_board !== exp_r || green_board !== exp_g || player !== 1'b0) begin
            fails++;
            $display("FAIL col3_unchanged: rejected=%b red=%h green=%h player=%b required 0 %h %h 0",
                     rejected, red_board, green_board, player, exp_r, exp_g);
        end
    endtask

    task automatic test_busy_enter();
        int     placed_n;
        int     k;
        bit     rej_seen;
        board_t exp;
        apply_reset();
        @(negedge clk);
        enter = 1'b1;
        column_select = 7'b0000010;
        @(negedge clk);
        enter = 1'b0;
        placed_n = 0;
        rej_seen = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            if (placed) placed_n++;
            if (k == 3) begin
                enter = 1'b1;
                column_select = 7'b0000100;
            end else begin
                enter = 1'b0;
            end
            if (k == 4 && rejected === 1'b1) rej_seen = 1'b1;
            k++;
            @(negedge clk);
        end
        enter = 1'b0;
        repeat (20) begin
            if (placed) placed_n++;
            @(negedge clk);
        end
        exp = '0;
        exp[0][1] = 1'b1;
        tests_run++;
        if (!rej_seen) begin
            fails++;
            $display("FAIL busy_reject: rejected pulse seen=%b required 1", rej_seen);
        end
        tests_run++;
        if (placed_n !== 1 || red_board !== exp || green_board !== '0 || player !== 1'b1) begin
            fails++;
            $display("FAIL busy_single_piece: placed=%0d red=%h green=%h player=%b required 1 %h 0 1",
                     placed_n, red_board, green_board, player, exp);
        end
    endtask

    task automatic test_reset_mid_drop();
        int bn, pn;
        bit tmo;
        bit quiet_ok;
        apply_reset();
        drop_and_wait(7'b0000001, bn, pn, tmo);
        @(negedge clk);
        enter = 1'b1;
        column_select = 7'b0010000;
        @(negedge clk);
        enter = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || player !== 1'b1) begin
            fails++;
            $display("FAIL middrop_setup: busy=%b player=%b required 1 1", busy, player);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || red_board !== '0 || green_board !== '0 || player !== 1'b0 || placed !== 1'b0) begin
            fails++;
            $display("FAIL middrop_async: busy=%b red=%h green=%h player=%b placed=%b required all 0",
                     busy, red_board, green_board, player, placed);
        end
        @(negedge clk);
        reset = 1'b0;
        quiet_ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (placed || busy || red_board != '0 || green_board != '0 || player) quiet_ok = 1'b0;
        end
        tests_run++;
        if (!quiet_ok) begin
            fails++;
            $display("FAIL middrop_discard: got activity after reset required none");
        end
    endtask

    task automatic test_board_full();
        int     bn, pn;
        bit     tmo;
        bit     colour_ok;
        bit     early_full;
        int     n;
        board_t exp_r;
        apply_reset();
        colour_ok = 1'b1;
        early_full = 1'b0;
        exp_r = '0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 7; c++) begin
                n = r * 7 + c;
                if (n == 41 && board_full !== 1'b0) early_full = 1'b1;
                drop_and_wait(7'(1 << c), bn, pn, tmo);
                if (tmo || pn != 1) colour_ok = 1'b0;
                if (n % 2 == 0) begin
                    exp_r[r][c] = 1'b1;
                    if (red_board[r][c] !== 1'b1 || green_board[r][c] !== 1'b0) colour_ok = 1'b0;
                end else begin
                    if (red_board[r][c] !== 1'b0 || green_board[r][c] !== 1'b1) colour_ok = 1'b0;
                end
            end
        end
        tests_run++;
        if (!colour_ok || early_full) begin
            fails++;
            $display("FAIL full_alternate: colours_ok=%b early_full=%b required 1 0", colour_ok, early_full);
        end
        tests_run++;
        if (board_full !== 1'b1 || column_full !== 7'h7f) begin
            fails++;
            $display("FAIL full_flags: board_full=%b column_full=%b required 1 1111111", board_full, column_full);
        end
        tests_run++;
        if (red_board !== exp_r || green_board !== ~exp_r || player !== 1'b0) begin
            fails++;
            $display("FAIL full_board: red=%h green=%h player=%b required %h %h 0",
                     red_board, green_board, player, exp_r, ~exp_r);
        end
        @(negedge clk);
        enter = 1'b1;
        column_select = 7'b1000000;
        @(negedge clk);
        enter = 1'b0;
        tests_run++;
        if (rejected !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL full_reject: rejected=%b busy=%b required 1 0", rejected, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_drop();
        test_invalid_select();
        test_column_full();
        test_busy_enter();
        test_reset_mid_drop();
        test_board_full();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/piece_dropper.md
PIECE_DROPPER -- requirements
Module: piece_dropper

Interface
REQ-001 SHALL have parameter DROP_TICKS, default 4: clock cycles the falling piece spends on each row.
REQ-002 SHALL have ports:
- clk, input, 1, the single clock.
- reset, input, 1, asynchronous active-high reset.
- enter, input, 1, single-cycle strobe requesting a drop into the selected column.
- column_select, input, 7, one-hot column; bit 0 = column 0.
- red_board, output, 6x7, committed red pieces plus the falling red piece; [row][col], row 0 = bottom.
- green_board, output, 6x7, same encoding for green.
- player, output, 1, side to move; 0 = red, 1 = green.
- busy, output, 1, high while a drop is in progress.
- placed, output, 1, one-cycle pulse when a piece commits.
- rejected, output, 1, one-cycle pulse when an enter is refused.
- column_full, output, 7, bit c high when column c holds 6 pieces.
- board_full, output, 1, high when all 42 cells are occupied.

Function
REQ-003 SHALL implement states IDLE, DROP, COMMIT.
REQ-004 SHALL, in IDLE, accept enter when column_select is exactly one-hot, column not full, board not full: capture column and target row = height[col]; next state DROP with fall_row = 5 and tick count = 0.
REQ-005 SHALL refuse any enter with zero or multiple bits set, on a full column, or with board full: rejected high the next cycle; no change to state, board, heights or player.
REQ-006 SHALL refuse enter while in DROP or COMMIT: rejected high the next cycle, request discarded, no queueing.
REQ-007 SHALL, in DROP, increment tick count each cycle; at DROP_TICKS-1, reset tick count, then go to COMMIT if fall_row equals target, else decrement fall_row.
REQ-008 SHALL keep total DROP residency at (6 - target) x DROP_TICKS cycles.
REQ-009 SHALL, during DROP and COMMIT, show the falling piece at (fall_row, col) in the current player's plane, OR'd with the committed board.
REQ-010 SHALL, in COMMIT (one cycle), assert placed, write the cell into the current player's committed plane, increment height[col], and toggle player at the following edge; next state IDLE.
REQ-011 SHALL drive busy = 1 in DROP and COMMIT, 0 in IDLE.
REQ-012 SHALL hold height[c] as a 3-bit count, 0..6, that never exceeds 6.
REQ-013 SHALL derive column_full[c] = (height[c] == 6) and board_full = AND of column_full, both combinationally.
REQ-014 SHALL register placed and rejected so each is high for exactly one cycle per event.

Reset
REQ-015 SHALL, on reset asserted at any time including mid-drop, asynchronously force: state IDLE; both boards 0; heights 0; player 0 (red); fall_row 5; tick count 0; placed and rejected 0.
REQ-016 SHALL discard any in-flight piece on reset; it is never committed.

Structure
REQ-017 SHALL take NUM_ROWS=6, NUM_COLS=7, the state enum and the player enum from shared package connect_four_pkg.
REQ-018 SHALL place the per-row tick counter in sub-module drop_timer (inputs clk, reset, clear, enable; output terminal), parameterised by DROP_TICKS.

Verification (DROP_TICKS=2)
REQ-019 SHALL cover: after reset, enter with column_select=0000001 -> busy for 13 cycles (12 DROP + 1 COMMIT); falling red piece on rows 5..0, 2 cycles each; placed pulse; red_board[0][0]=1; player=1.
REQ-020 SHALL cover: six accepted drops into column 3 -> column_full=0001000; seventh enter -> rejected pulse, boards and player unchanged.
REQ-021 SHALL cover: enter with column_select=0000101 and with 0000000 -> rejected pulse each, busy stays 0.
REQ-022 SHALL cover: second enter while busy -> rejected pulse, only one piece placed.
REQ-023 SHALL cover: reset asserted mid-drop -> outputs cleared immediately without waiting for clk, no placed pulse, player=0.
REQ-024 SHALL cover: fill all 42 cells by alternating columns -> board_full=1, colours alternate red/green per placement, next enter -> rejected.
